// File: rtl/conware_pkg.sv
// Shared definitions for the conware frame controller: state encoding,
// frame counter width and a small state classification helper.
package conware_pkg;

  localparam int FRAME_CNT_W = 16;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_GRANT   = 3'd1;
  localparam logic [2:0] ENC_FETCH   = 3'd2;
  localparam logic [2:0] ENC_LOAD    = 3'd3;
  localparam logic [2:0] ENC_PRESENT = 3'd4;
  localparam logic [2:0] ENC_DONE    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = ENC_IDLE,
    ST_GRANT   = ENC_GRANT,
    ST_FETCH   = ENC_FETCH,
    ST_LOAD    = ENC_LOAD,
    ST_PRESENT = ENC_PRESENT,
    ST_DONE    = ENC_DONE
  } state_e;

  // A frame is in progress from the first row fetch through the done cycle.
  function automatic logic is_busy(state_e s);
    return (s == ST_FETCH) || (s == ST_LOAD) || (s == ST_PRESENT) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/conware_frame_ctrl.sv
// Frame render controller: arbitrates board memory between the generation
// engine and the row streamer, reads one row at a time and hands each row
// word to the serializer with a valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no frame in flight, memory free
// GRANT   | board memory owned by generation engine
// FETCH   | read strobe for current row
// LOAD    | read data returning, captured into out_data at cycle end
// PRESENT | row word offered to serializer until accepted
// DONE    | one-cycle frame completion, frame counter bumps
module conware_frame_ctrl
  import conware_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 4,
  parameter int AWIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   compute_req,
  output logic                   compute_gnt,
  output logic [AWIDTH-1:0]      mem_addr,
  output logic                   mem_rd_en,
  input  logic [WIDTH-1:0]       mem_rd_data,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [AWIDTH-1:0] LAST_ROW = AWIDTH'(HEIGHT - 1);

  state_e                   state_q, state_d;
  logic [AWIDTH-1:0]        row_q, row_d;
  logic                     pending_q, pending_d;
  logic [FRAME_CNT_W-1:0]   frame_count_q;
  logic [WIDTH-1:0]         out_data_q;
  logic                     out_valid_q;
  logic                     mem_rd_en_q;
  logic [AWIDTH-1:0]        mem_addr_q;
  logic                     compute_gnt_q;
  logic                     frame_done_q;
  logic                     frame_busy_q;

  // Next-state, row index and pending-start decisions.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    pending_d = pending_q;
    // A start that cannot be served right now is remembered once.
    if (start && (state_q != ST_IDLE)) pending_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (compute_req) begin
          state_d = ST_GRANT;
          if (start) pending_d = 1'b1;
        end else if (start || pending_q) begin
          state_d   = ST_FETCH;
          row_d     = '0;
          pending_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!compute_req) state_d = ST_IDLE;
      end
      ST_FETCH:   state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_PRESENT;
      ST_PRESENT: begin
        if (out_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            row_d   = row_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // Compute requests win; going through IDLE lets the grant follow.
        if (compute_req) begin
          state_d = ST_IDLE;
        end else if (continuous || pending_q) begin
          state_d   = ST_FETCH;
          row_d     = '0;
          pending_d = start;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      row_q         <= '0;
      pending_q     <= 1'b0;
      frame_count_q <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      compute_gnt_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_busy_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      pending_q     <= pending_d;
      mem_rd_en_q   <= (state_d == ST_FETCH);
      mem_addr_q    <= (state_d == ST_FETCH) ? row_d : '0;
      out_valid_q   <= (state_d == ST_PRESENT);
      compute_gnt_q <= (state_d == ST_GRANT);
      frame_done_q  <= (state_d == ST_DONE);
      frame_busy_q  <= is_busy(state_d);
      if (state_q == ST_LOAD) out_data_q <= mem_rd_data;
      if (state_d == ST_DONE) frame_count_q <= frame_count_q + 1'b1;
    end
  end

  assign compute_gnt = compute_gnt_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign frame_busy  = frame_busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_conware_frame_ctrl.sv
// Scoreboard bench for conware_frame_ctrl: stimulus pushes expected row words
// and frame counts; a negedge monitor pops and compares on each handshake.
module tb_conware_frame_ctrl;
  import conware_pkg::*;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 4;
  localparam int AWIDTH = 8;

  logic                   clk = 1'b0;
  logic                   rstn, start, continuous, compute_req, out_ready;
  logic                   compute_gnt, mem_rd_en, out_valid, frame_busy, frame_done;
  logic [AWIDTH-1:0]      mem_addr;
  logic [WIDTH-1:0]       mem_rd_data = '0;
  logic [WIDTH-1:0]       out_data;
  logic [FRAME_CNT_W-1:0] frame_count;

  conware_frame_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AWIDTH(AWIDTH)) dut (
    .clk(clk), .rstn(rstn), .start(start), .continuous(continuous),
    .compute_req(compute_req), .compute_gnt(compute_gnt), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .frame_busy(frame_busy),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // board memory model: one-cycle read latency
  logic [WIDTH-1:0] board [HEIGHT];
  initial begin
    board[0] = 4'h1; board[1] = 4'h2; board[2] = 4'h4; board[3] = 4'h8;
  end
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= board[mem_addr[1:0]];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  logic [WIDTH-1:0]       exp_data_q [$];
  logic [FRAME_CNT_W-1:0] exp_cnt_q  [$];
  int                     acc_cyc    [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: handshake pops, frame_done pops, exclusivity invariants
  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      if (mem_rd_en) rd_cnt++;
      if (compute_gnt) begin
        chk("gnt_vs_rd", {31'd0, mem_rd_en}, 32'd0);
        chk("gnt_vs_busy", {31'd0, frame_busy}, 32'd0);
      end
      if (out_valid && out_ready) begin
        acc_cyc.push_back(cyc);
        if (exp_data_q.size() == 0) chk("row_unexpected", {28'd0, out_data}, 32'hFFFF_FFFF);
        else chk("row_data", {28'd0, out_data}, {28'd0, exp_data_q.pop_front()});
      end
      if (frame_done) begin
        done_cnt++;
        if (exp_cnt_q.size() == 0) chk("done_unexpected", {16'd0, frame_count}, 32'hFFFF_FFFF);
        else chk("done_count", {16'd0, frame_count}, {16'd0, exp_cnt_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk(name, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (frame_busy && n < 80) begin tick(); n++; end
    chk(name, {31'd0, frame_busy}, 32'd0);
  endtask

  task automatic push_frame(input logic [FRAME_CNT_W-1:0] cnt);
    exp_data_q.push_back(4'h1); exp_data_q.push_back(4'h2);
    exp_data_q.push_back(4'h4); exp_data_q.push_back(4'h8);
    exp_cnt_q.push_back(cnt);
  endtask

  initial begin
    int d0, r0, gaps;
    rstn = 1'b0; start = 1'b0; continuous = 1'b0; compute_req = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_gnt",   {31'd0, compute_gnt}, 32'd0);
    chk("rst_count", {16'd0, frame_count}, 32'd0);
    chk("rst_data",  {28'd0, out_data}, 32'd0);
    rstn = 1'b1;
    tick();

    // basic frame, latency and 3-cycle row cadence
    push_frame(16'd1);
    acc_cyc.delete();
    d0 = done_cnt;
    pulse_start();
    chk("lat_fetch_rd", {31'd0, mem_rd_en}, 32'd1);
    chk("lat_fetch_addr", {24'd0, mem_addr}, 32'd0);
    chk("lat_fetch_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_load_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_present_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_present_data", {28'd0, out_data}, 32'h1);
    wait_idle("idle_basic");
    chk("basic_accepts", acc_cyc.size(), 32'd4);
    for (int i = 1; i < 4 && i < acc_cyc.size(); i++)
      chk("row_cadence", acc_cyc[i] - acc_cyc[i-1], 32'd3);
    chk("basic_done_pulses", done_cnt - d0, 32'd1);
    chk("basic_count", {16'd0, frame_count}, 32'd1);

    // back-pressure on row 2
    push_frame(16'd2);
    out_ready = 1'b0;
    pulse_start();
    for (int r = 0; r < 4; r++) begin
      wait_valid("bp_wait_valid");
      if (r == 2) begin
        r0 = rd_cnt;
        for (int k = 0; k < 5; k++) begin
          tick();
          chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
          chk("bp_data_stable", {28'd0, out_data}, 32'h4);
        end
        chk("bp_no_extra_rd", rd_cnt - r0, 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    wait_idle("idle_bp");
    chk("bp_count", {16'd0, frame_count}, 32'd2);
    out_ready = 1'b1;

    // compute request and start together: grant first, frame from pending start
    push_frame(16'd3);
    compute_req = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("grant_first", {31'd0, compute_gnt}, 32'd1);
    r0 = rd_cnt;
    repeat (3) begin
      tick();
      chk("grant_held", {31'd0, compute_gnt}, 32'd1);
    end
    compute_req = 1'b0;
    tick();
    chk("grant_dropped", {31'd0, compute_gnt}, 32'd0);
    chk("grant_no_rd", rd_cnt - r0, 32'd0);
    tick();
    chk("pending_fetch", {31'd0, mem_rd_en}, 32'd1);
    wait_idle("idle_pending");
    chk("pending_count", {16'd0, frame_count}, 32'd3);

    // continuous: three frames back to back
    push_frame(16'd4); push_frame(16'd5); push_frame(16'd6);
    continuous = 1'b1;
    d0 = done_cnt;
    gaps = 0;
    pulse_start();
    begin
      int n = 0;
      while (done_cnt < d0 + 2 && n < 80) begin
        if (!frame_busy) gaps++;
        tick(); n++;
      end
    end
    chk("cont_two_frames", done_cnt - d0, 32'd2);
    continuous = 1'b0;
    begin
      int n = 0;
      while (done_cnt < d0 + 3 && n < 80) begin
        if (!frame_busy) gaps++;
        tick(); n++;
      end
    end
    chk("cont_no_idle", gaps, 32'd0);
    wait_idle("idle_cont");
    chk("cont_count", {16'd0, frame_count}, 32'd6);

    // reset during PRESENT of row 1
    exp_data_q.push_back(4'h1);
    out_ready = 1'b0;
    d0 = done_cnt;
    pulse_start();
    wait_valid("rst_wait_row0");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_valid("rst_wait_row1");
    chk("rst_row1_data", {28'd0, out_data}, 32'h2);
    rstn = 1'b0;
    tick();
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data",  {28'd0, out_data}, 32'd0);
    chk("midrst_busy",  {31'd0, frame_busy}, 32'd0);
    chk("midrst_done",  {31'd0, frame_done}, 32'd0);
    chk("midrst_count", {16'd0, frame_count}, 32'd0);
    rstn = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("midrst_no_done", done_cnt - d0, 32'd0);
    chk("midrst_stays_idle", {31'd0, frame_busy}, 32'd0);

    // frame counter wrap
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    tick();
    chk("wrap_preset", {16'd0, frame_count}, 32'hFFFF);
    push_frame(16'h0000);
    pulse_start();
    wait_idle("idle_wrap");
    chk("wrap_count", {16'd0, frame_count}, 32'h0);

    tick();
    chk("data_queue_empty", exp_data_q.size(), 32'd0);
    chk("cnt_queue_empty", exp_cnt_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
